// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin sequencer for the shared 8:1 dual-rail mux (select, guard, dwell)
module mux_rr_scheduler #(
  parameter int DWELL = 4,
  parameter int GUARD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] REQ,
  output logic       A1,
  output logic       A2,
  output logic       A4,
  output logic       EZ,
  output logic [7:0] GNT,
  output logic       BUSY
);
  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_GRANT} state_t;
  state_t     state;
  logic [2:0] sel, ptr, win;
  logic       hit;
  logic [3:0] gcnt;
  logic [7:0] dcnt;
  // ptr equals sel throughout GRANT, so one arbiter based on ptr serves both IDLE and grant end
  always_comb begin
    win = ptr;
    hit = 1'b0;
    for (int k = 8; k >= 1; k--)
      if (REQ[ptr + 3'(k)]) begin
        win = ptr + 3'(k);
        hit = 1'b1;
      end
  end
  assign {A1, A2, A4} = sel;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sel   <= '0;
      ptr   <= 3'd7;
      gcnt  <= '0;
      dcnt  <= '0;
      EZ    <= 1'b1;
      GNT   <= '0;
      BUSY  <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (hit) begin
            sel   <= win;
            state <= S_GUARD;
            gcnt  <= '0;
            BUSY  <= 1'b1;
          end
        S_GUARD:
          if (gcnt == 4'(GUARD - 1)) begin
            if (REQ[sel]) begin
              state <= S_GRANT;
              ptr   <= sel;
              dcnt  <= '0;
              EZ    <= 1'b0;
              GNT   <= 8'd1 << sel;
            end else begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end
          end else gcnt <= gcnt + 4'd1;
        S_GRANT:
          if (!REQ[sel] || dcnt == 8'(DWELL - 1)) begin
            if (!hit) begin
              state <= S_IDLE;
              EZ    <= 1'b1;
              GNT   <= '0;
              BUSY  <= 1'b0;
            end else if (win == sel) dcnt <= '0;
            else begin
              sel   <= win;
              state <= S_GUARD;
              gcnt  <= '0;
              EZ    <= 1'b1;
              GNT   <= '0;
            end
          end else dcnt <= dcnt + 8'd1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb_mux_rr_scheduler: directed checks of grant order, guard gaps, dwell, release, abandon and reset
module tb_mux_rr_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] req0 = '0, req1 = '0;
  logic a1_0, a2_0, a4_0, ez0, busy0, a1_1, a2_1, a4_1, ez1, busy1;
  logic [7:0] gnt0, gnt1;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  mux_rr_scheduler #(.DWELL(4), .GUARD(1)) u0 (
    .clk(clk), .rst(rst), .REQ(req0), .A1(a1_0), .A2(a2_0), .A4(a4_0),
    .EZ(ez0), .GNT(gnt0), .BUSY(busy0)
  );
  mux_rr_scheduler #(.DWELL(4), .GUARD(3)) u1 (
    .clk(clk), .rst(rst), .REQ(req1), .A1(a1_1), .A2(a2_1), .A4(a4_1),
    .EZ(ez1), .GNT(gnt1), .BUSY(busy1)
  );
  wire [12:0] o0 = {busy0, ez0, a1_0, a2_0, a4_0, gnt0};
  wire [12:0] o1 = {busy1, ez1, a1_1, a2_1, a4_1, gnt1};
  // observed/expected layout: {BUSY, EZ, sel[2:0], GNT[7:0]}
  function automatic logic [12:0] st(input logic b, input logic e, input logic [2:0] s, input logic [7:0] g);
    return {b, e, s, g};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    req0 = 8'hFF;
    repeat (3) tick();
    chk("reset", o0, st(0, 1, 0, 8'h00));
    chk("reset_u1", o1, st(0, 1, 0, 8'h00));
    rst = 1'b0;
    tick();
    chk("first_guard", o0, st(1, 1, 0, 8'h00));
    tick();
    // all requesting: 4-cycle grants separated by single guard cycles, in order 0..7
    for (int c = 0; c < 8; c++) begin
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("rr_grant%0d_%0d", c, d), o0, st(1, 0, 3'(c), 8'd1 << c));
        tick();
      end
      chk($sformatf("rr_gap%0d", c), o0, st(1, 1, 3'((c + 1) % 8), 8'h00));
      tick();
    end
    chk("rr_wrap", o0, st(1, 0, 0, 8'h01));
    req0 = 8'h05;
    tick();
    chk("early_g0", o0, st(1, 0, 0, 8'h01));
    req0 = 8'h04;
    tick();
    chk("early_gap", o0, st(1, 1, 2, 8'h00));
    tick();
    chk("early_g2", o0, st(1, 0, 2, 8'h04));
    req0 = 8'h08;
    tick();
    chk("single_gap", o0, st(1, 1, 3, 8'h00));
    tick();
    chk("single_first", o0, st(1, 0, 3, 8'h08));
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("single_hold%0d", i), o0, st(1, 0, 3, 8'h08));
    end
    req0 = 8'h00;
    tick();
    chk("single_drop", o0, st(0, 1, 3, 8'h00));
    req0 = 8'h20;
    tick();
    chk("ch5_guard", o0, st(1, 1, 5, 8'h00));
    tick();
    chk("ch5_d0", o0, st(1, 0, 5, 8'h20));
    tick();
    tick();
    chk("ch5_d2", o0, st(1, 0, 5, 8'h20));
    rst = 1'b1;
    tick();
    chk("mid_reset", o0, st(0, 1, 0, 8'h00));
    rst = 1'b0;
    req0 = 8'hFF;
    tick();
    chk("ptr_after_reset", o0, st(1, 1, 0, 8'h00));
    req0 = 8'h00;
    tick();
    chk("abandon_u0", o0, st(0, 1, 0, 8'h00));
    req1 = 8'h10;
    tick();
    chk("ab_guard0", o1, st(1, 1, 4, 8'h00));
    req1 = 8'h00;
    tick();
    chk("ab_guard1", o1, st(1, 1, 4, 8'h00));
    tick();
    chk("ab_guard2", o1, st(1, 1, 4, 8'h00));
    tick();
    chk("ab_idle", o1, st(0, 1, 4, 8'h00));
    req1 = 8'h30;
    tick();
    chk("ab_reguard0", o1, st(1, 1, 4, 8'h00));
    tick();
    tick();
    chk("ab_reguard2", o1, st(1, 1, 4, 8'h00));
    tick();
    chk("ab_grant4", o1, st(1, 0, 4, 8'h10));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
Round-robin scheduler that shares the 8:1 dual-rail multiplexer (inputs X0..X7, selects A1/A2/A4, tri-state enable EZ) among eight requesters. It sequences the mux: it picks a winner, drives the select lines, and enables the outputs for a bounded dwell time. Between winners it inserts guard cycles with EZ high, so the shared output bus is never driven during a select change. It sits directly in front of the mux instance and owns all of its control inputs.

Parameters:
DWELL, 4, maximum consecutive grant cycles per channel before re-arbitration (legal range 1..255)
GUARD, 1, EZ-high cycles between two grants to different channels (legal range 1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
REQ  input  8  request per channel; REQ[i] asks for mux input Xi
A1  output  1  mux select MSB (weight 4)
A2  output  1  mux select bit (weight 2)
A4  output  1  mux select LSB (weight 1)
EZ  output  1  mux output disable; 1 = Y0/Y1 high-Z
GNT  output  8  one-hot grant, equal to 1<<sel while in GRANT, else 0
BUSY  output  1  1 in GUARD or GRANT

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Select encoding: sel = {A1,A2,A4}, with A1 as MSB. sel = i routes Xi to Y0 and ~Xi to Y1.
- Reset: state IDLE; {A1,A2,A4}=000; EZ=1; GNT=0; BUSY=0; round-robin pointer ptr=7, so channel 0 has first priority; counters=0.
- Reset asserted mid-GRANT or mid-GUARD: EZ=1 and GNT=0 on the next edge. No partial grant is completed.
- Arbitration: the winner is the first i with REQ[i]=1, searching ptr+1, ptr+2, ... mod 8.
- ptr updates to the winner when the winner enters GRANT.
- States:
  - IDLE: EZ=1, GNT=0, BUSY=0, select holds its last value. If REQ≠0, latch the winner into sel and go to GUARD with gcnt=0.
  - GUARD: EZ=1, GNT=0, BUSY=1; sel is already stable at the winner; gcnt increments each cycle.
    - When gcnt=GUARD-1 and REQ[sel]=1: go to GRANT with dcnt=0.
    - When gcnt=GUARD-1 and REQ[sel]=0: go to IDLE. This is an abandoned grant; ptr is unchanged.
  - GRANT: EZ=0, GNT=1<<sel, BUSY=1; dcnt increments each cycle.
    - The grant ends when REQ[sel]=0 (early release) or when dcnt=DWELL-1 (dwell expiry).
    - At grant end, re-arbitrate with ptr=sel.
    - No requests: go to IDLE; EZ=1 on the next cycle.
    - Winner equals the current sel (sole requester, dwell expired): stay in GRANT, dcnt=0, EZ stays 0, no guard.
    - Winner differs: load the new sel and go to GUARD; EZ=1 in the same cycle the select changes.
- Invariant: EZ=0 only while state=GRANT; sel never changes while EZ=0.
- Latency: REQ rises at edge n in IDLE. GUARD is entered at n+1, and EZ falls at edge n+1+GUARD.
- Requests that change during GUARD do not alter the latched winner. Only REQ[sel] is sampled at the end of GUARD.
- Fairness: with all 8 requesting continuously, grants cycle 0,1,...,7,0. Each grant lasts DWELL cycles and is separated by GUARD cycles.
- Counters: dcnt is 8 bits and gcnt is 4 bits, and both saturate-free within the legal ranges. Out-of-range parameters are not supported.

Test Plan:
- Reset: hold rst 3 cycles with REQ=FF, then check EZ=1, GNT=00, BUSY=0, select=000. Release rst → IDLE, then GUARD at sel=0, then GNT=01 with EZ=0 after 1 guard cycle.
- Single requester, DWELL=4: REQ=08 held for 20 cycles → sel=3, GNT=08 continuous, EZ stays 0 with no guard gaps after the first grant. Drop REQ → EZ=1 and GNT=00 on the next edge.
- All requesting, DWELL=4, GUARD=1: REQ=FF → GNT sequence 01,02,04,...,80,01. Each is exactly 4 cycles with a 1-cycle EZ=1 gap, and sel changes only in gap cycles.
- Early release: REQ=05, then drop bit 0 after 2 grant cycles → grant 0 lasts 2 cycles, 1 guard cycle follows, then GNT=04.
- Abandoned guard (GUARD=3): REQ=10 pulsed for 1 cycle in IDLE → GUARD at sel=4 for 3 cycles, then IDLE, with EZ=1 throughout. A following REQ=30 then grants 4 first, because ptr is unchanged.
- Reset mid-grant: assert rst in dcnt=2 of the channel-5 grant → next edge EZ=1, GNT=00, select=000, ptr=7.
